// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : regfile_wb_arbiter_pkg                                          |
// | Brief  : Shared types and constants for the register-file write arbiter. |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package regfile_wb_arbiter_pkg;

    localparam int unsigned REG_NUM = 32;

    typedef logic        bit_t;
    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] reg_data_t;

    localparam reg_addr_t REG_ZERO  = 5'd0;
    localparam bit_t      ENABLE    = 1'b1;
    localparam bit_t      DISABLE   = 1'b0;
    localparam reg_data_t ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        WBA_IDLE  = 2'd0,
        WBA_HOLD  = 2'd1,
        WBA_STALL = 2'd2
    } wb_arb_state_t;

    // r0 is hardwired; nothing may ever target it
    function automatic bit_t is_writable(input reg_addr_t addr);
        return (addr != REG_ZERO) ? ENABLE : DISABLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : regfile_wb_arbiter_if                                           |
// | Brief  : WB-stage, long-unit and regfile write-port bundle.              |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;

    logic                pipe_we;
    reg_addr_t           pipe_waddr;
    reg_data_t           pipe_wdata;
    logic                lu_issue;
    reg_addr_t           lu_issue_addr;
    logic                lu_valid;
    reg_addr_t           lu_waddr;
    reg_data_t           lu_wdata;
    logic                lu_ready;
    logic                stall_req;
    logic [REG_NUM-1:0]  pending;
    logic                write_enable;
    reg_addr_t           write_addr;
    reg_data_t           write_data;

    modport slave (
        input  pipe_we, pipe_waddr, pipe_wdata,
        input  lu_issue, lu_issue_addr,
        input  lu_valid, lu_waddr, lu_wdata,
        output lu_ready, stall_req, pending,
        output write_enable, write_addr, write_data
    );

    modport master (
        output pipe_we, pipe_waddr, pipe_wdata,
        output lu_issue, lu_issue_addr,
        output lu_valid, lu_waddr, lu_wdata,
        input  lu_ready, stall_req, pending,
        input  write_enable, write_addr, write_data
    );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : wb_scoreboard                                                   |
// | Brief  : Pending-write mask for registers awaiting a long-unit result.   |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned REG_NUM_P = REG_NUM
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  reg_addr_t            set_addr,
    input  logic                 clr_en,
    input  reg_addr_t            clr_addr,
    output logic [REG_NUM_P-1:0] pending
);

    logic [REG_NUM_P-1:0] pending_q;
    logic [REG_NUM_P-1:0] pending_d;

    // Set is applied after clear so a same-cycle reissue keeps the bit
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            pending_d[set_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : regfile_wb_arbiter                                              |
// | Brief  : Register-file write-port owner merging WB-stage and long-unit   |
// |          writes; WB_ARB_STARVE_EN enables the HOLD->STALL escalation.    |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
)(
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    if (MAX_WAIT < 1) begin : g_max_wait_check
        $error("MAX_WAIT must be at least 1");
    end

    wb_arb_state_t state_q, state_d;
    reg_addr_t     buf_addr_q, buf_addr_d;
    reg_data_t     buf_data_q, buf_data_d;

    logic          w_sel_we;
    reg_addr_t     w_sel_addr;
    reg_data_t     w_sel_data;
    logic          w_lu_ready;
    logic          w_stall_req;
    logic          w_clr_en;
    reg_addr_t     w_clr_addr;
    logic          w_write_enable;

`ifdef WB_ARB_STARVE_EN
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    // The capture cycle already counts as one wait behind the pipe
    localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        w_sel_we    = DISABLE;
        w_sel_addr  = REG_ZERO;
        w_sel_data  = ZERO_WORD;
        w_lu_ready  = DISABLE;
        w_stall_req = DISABLE;
        w_clr_en    = DISABLE;
        w_clr_addr  = REG_ZERO;
`ifdef WB_ARB_STARVE_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        if (rst) begin
            case (state_q)
                WBA_IDLE: begin
                    w_lu_ready = ENABLE;
                    if (bus.pipe_we) begin
                        w_sel_we   = ENABLE;
                        w_sel_addr = bus.pipe_waddr;
                        w_sel_data = bus.pipe_wdata;
                        if (bus.lu_valid && is_writable(bus.lu_waddr)) begin
                            buf_addr_d = bus.lu_waddr;
                            buf_data_d = bus.lu_wdata;
                            state_d    = WBA_HOLD;
`ifdef WB_ARB_STARVE_EN
                            wait_cnt_d = '0;
`endif
                        end
                    end else if (bus.lu_valid) begin
                        w_sel_we   = ENABLE;
                        w_sel_addr = bus.lu_waddr;
                        w_sel_data = bus.lu_wdata;
                        w_clr_en   = ENABLE;
                        w_clr_addr = bus.lu_waddr;
                    end
                end
                WBA_HOLD: begin
                    w_clr_addr = buf_addr_q;
                    if (!bus.pipe_we) begin
                        w_sel_we   = ENABLE;
                        w_sel_addr = buf_addr_q;
                        w_sel_data = buf_data_q;
                        w_clr_en   = ENABLE;
                        state_d    = WBA_IDLE;
                    end else begin
                        w_sel_we   = ENABLE;
                        w_sel_addr = bus.pipe_waddr;
                        w_sel_data = bus.pipe_wdata;
                        // Younger pipe write to the same register supersedes the buffer
                        if (bus.pipe_waddr == buf_addr_q) begin
                            w_clr_en = ENABLE;
                            state_d  = WBA_IDLE;
                        end else begin
`ifdef WB_ARB_STARVE_EN
                            wait_cnt_d = wait_cnt_q + CNT_W'(1);
                            if (wait_cnt_d >= STALL_AT) begin
                                state_d = WBA_STALL;
                            end
`endif
                        end
                    end
                end
`ifdef WB_ARB_STARVE_EN
                WBA_STALL: begin
                    w_stall_req = ENABLE;
                    w_sel_we    = ENABLE;
                    w_sel_addr  = buf_addr_q;
                    w_sel_data  = buf_data_q;
                    w_clr_en    = ENABLE;
                    w_clr_addr  = buf_addr_q;
                    state_d     = WBA_IDLE;
                end
`endif
                default: begin
                    state_d = WBA_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= WBA_IDLE;
            buf_addr_q <= REG_ZERO;
            buf_data_q <= ZERO_WORD;
        end else begin
            state_q    <= state_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
        end
    end

`ifdef WB_ARB_STARVE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign w_write_enable   = w_sel_we && is_writable(w_sel_addr);
    assign bus.write_enable = w_write_enable;
    assign bus.write_addr   = w_write_enable ? w_sel_addr : REG_ZERO;
    assign bus.write_data   = w_write_enable ? w_sel_data : ZERO_WORD;
    assign bus.lu_ready     = w_lu_ready;
    assign bus.stall_req    = w_stall_req;

    wb_scoreboard #(
        .REG_NUM_P (REG_NUM)
    ) u_wb_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (bus.lu_issue),
        .set_addr (bus.lu_issue_addr),
        .clr_en   (w_clr_en),
        .clr_addr (w_clr_addr),
        .pending  (bus.pending)
    );

endmodule
`default_nettype wire
